// File: rtl/mem_rr_controller.sv
// Round-robin controller sharing one 16x32 registered memory port between two requesters.
// It zero-fills the memory after reset, then serves one transaction at a time.
module mem_rr_controller #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          init_done,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {StInit, StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          rr_last_q, rr_last_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          grant_valid;
  logic          grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      rr_last_q  <= 1'b1;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_last_q  <= rr_last_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // A lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = (req0 && req1) ? ~rr_last_q : req1;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_last_d  = rr_last_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (&init_cnt_q) state_d = StIdle;
      end
      StIdle: begin
        if (grant_valid) begin
          owner_d   = grant_id;
          rr_last_d = grant_id;
          wr_d      = grant_id ? wr1 : wr0;
          addr_d    = grant_id ? addr1 : addr0;
          wdata_d   = grant_id ? wdata1 : wdata0;
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (!wr_q) begin
          if (owner_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  // Strobes and acks are gated by rst so nothing fires while reset is held.
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    if (state_q == StInit) begin
      mem_wr   = ~rst;
      mem_addr = init_cnt_q;
    end else if (state_q == StIssue) begin
      mem_wr    = ~rst & wr_q;
      mem_rd    = ~rst & ~wr_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end else if (state_q == StDone) begin
      ack0 = ~rst & ~owner_q;
      ack1 = ~rst & owner_q;
    end
  end

  assign init_done = (state_q != StInit);
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_rr_controller.sv
// Directed bench for mem_rr_controller with a registered 16x32 memory model whose
// initial contents are nonzero, so a missing zero-fill shows up on readback.
module tb_mem_rr_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [3:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        init_done;
  logic        mem_wr, mem_rd;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cyc [8];
  int ack_who [8];
  int ack_cnt, both_cnt, early_cnt;

  mem_rr_controller #(.AW(4), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .init_done (init_done),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
  end

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // Called at posedge+1; leaves the DUT in INIT cycle 0 with rst low.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_init();
    repeat (16) step();
  endtask

  // Cycle 0 is the cycle in progress on entry; returns at the negedge of the last ack.
  task automatic collect(input int max_cyc, input int nacks, input int raise1_at);
    ack_cnt = 0; both_cnt = 0; early_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      ack_cyc[k] = -1;
      ack_who[k] = -1;
    end
    for (int c = 0; c < max_cyc; c++) begin
      if (c == raise1_at) req1 = 1'b1;
      @(negedge clk);
      if (ack0 && ack1) both_cnt++;
      if ((ack0 || ack1) && !init_done) early_cnt++;
      if ((ack0 || ack1) && ack_cnt < 8) begin
        ack_cyc[ack_cnt] = c;
        ack_who[ack_cnt] = ack1 ? 1 : 0;
        ack_cnt++;
      end
      if (ack_cnt == nacks) return;
      step();
    end
  endtask

  task automatic xact(input logic who, input logic w, input logic [3:0] a, input logic [31:0] d);
    if (who) begin
      req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
    end
    collect(12, 1, -1);
    clear_reqs();
    step();
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, init_done, mem_wr, mem_rd} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 00000", {ack0, ack1, init_done, mem_wr, mem_rd});
    end
    n_cmp++;
    if ({rdata0, rdata1} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h required 0", {rdata0, rdata1});
    end
  endtask

  task automatic test_init();
    logic [38:0] exp_v;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_v = {1'b1, 1'b0, 1'b0, 4'(i), 32'h0};
      n_cmp++;
      if ({mem_wr, mem_rd, init_done, mem_addr, mem_wdata} !== exp_v) begin
        n_bad++;
        $display("FAIL init_cycle%0d: got %h required %h", i,
                 {mem_wr, mem_rd, init_done, mem_addr, mem_wdata}, exp_v);
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if ({init_done, mem_wr, mem_rd} !== 3'b100) begin
      n_bad++;
      $display("FAIL init_done_c17: got %b required 100", {init_done, mem_wr, mem_rd});
    end
    step();
    xact(1'b0, 1'b0, 4'd7, 32'h0);
    n_cmp++;
    if ({ack_cnt, ack_cyc[0], ack_who[0]} !== {32'd1, 32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL init_read7_ack: got cnt=%0d cyc=%0d who=%0d required 1/3/0",
               ack_cnt, ack_cyc[0], ack_who[0]);
    end
    n_cmp++;
    if (rdata0 !== 32'h0) begin
      n_bad++;
      $display("FAIL init_read7_data: got %h required 0", rdata0);
    end
  endtask

  task automatic test_write_read();
    xact(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    n_cmp++;
    if ({ack_cnt, ack_cyc[0], ack_who[0]} !== {32'd1, 32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL wr3_ack: got cnt=%0d cyc=%0d who=%0d required 1/3/0",
               ack_cnt, ack_cyc[0], ack_who[0]);
    end
    xact(1'b0, 1'b0, 4'd3, 32'h0);
    n_cmp++;
    if ({ack_cnt, ack_cyc[0], ack_who[0]} !== {32'd1, 32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL rd3_ack: got cnt=%0d cyc=%0d who=%0d required 1/3/0",
               ack_cnt, ack_cyc[0], ack_who[0]);
    end
    n_cmp++;
    if ({rdata0, rdata1} !== {32'hDEAD_BEEF, 32'h0}) begin
      n_bad++;
      $display("FAIL rd3_data: got %h required deadbeef00000000", {rdata0, rdata1});
    end
  endtask

  task automatic test_rr_both();
    do_reset();
    wait_init();
    xact(1'b1, 1'b1, 4'd2, 32'h0000_AAAA);
    xact(1'b1, 1'b1, 4'd9, 32'h0000_5555);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd2;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd9;
    collect(30, 4, -1);
    clear_reqs();
    step();
    n_cmp++;
    if (ack_cnt !== 4) begin
      n_bad++;
      $display("FAIL rr_count: got %0d required 4", ack_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ack_cyc[k] !== 3 + 4 * k || ack_who[k] !== k % 2) begin
        n_bad++;
        $display("FAIL rr_ack%0d: got cyc=%0d who=%0d required cyc=%0d who=%0d", k,
                 ack_cyc[k], ack_who[k], 3 + 4 * k, k % 2);
      end
    end
    n_cmp++;
    if (both_cnt !== 0) begin
      n_bad++;
      $display("FAIL rr_both_acks: got %0d required 0", both_cnt);
    end
    n_cmp++;
    if ({rdata0, rdata1} !== {32'h0000_AAAA, 32'h0000_5555}) begin
      n_bad++;
      $display("FAIL rr_data: got %h required 0000aaaa00005555", {rdata0, rdata1});
    end
  endtask

  task automatic test_req_during_init();
    do_reset();
    req1 = 1'b1; wr1 = 1'b1; addr1 = 4'd15; wdata1 = 32'h1;
    collect(30, 1, -1);
    clear_reqs();
    step();
    n_cmp++;
    if ({ack_cnt, ack_cyc[0], ack_who[0], early_cnt} !== {32'd1, 32'd19, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL init_req_ack: got cnt=%0d cyc=%0d who=%0d early=%0d required 1/19/1/0",
               ack_cnt, ack_cyc[0], ack_who[0], early_cnt);
    end
    xact(1'b0, 1'b0, 4'd15, 32'h0);
    n_cmp++;
    if (rdata0 !== 32'h1) begin
      n_bad++;
      $display("FAIL init_req_data: got %h required 1", rdata0);
    end
  endtask

  task automatic test_reset_in_wait();
    xact(1'b0, 1'b1, 4'd4, 32'hCAFE_F00D);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd4;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, mem_wr, mem_rd} !== 4'b0) begin
      n_bad++;
      $display("FAIL abort_wait_outs: got %b required 0000", {ack0, ack1, mem_wr, mem_rd});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    n_cmp++;
    if ({mem_wr, mem_addr, init_done, ack0, rdata0} !== {1'b1, 4'd0, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL abort_restart: got wr=%b addr=%0d done=%b ack0=%b rdata0=%h required 1/0/0/0/0",
               mem_wr, mem_addr, init_done, ack0, rdata0);
    end
    step();
    collect(15, 1, -1);
    n_cmp++;
    if (ack_cnt !== 0) begin
      n_bad++;
      $display("FAIL abort_no_ack: got %0d acks required 0", ack_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_init_done: got %b required 1", init_done);
    end
    step();
    xact(1'b0, 1'b0, 4'd4, 32'h0);
    n_cmp++;
    if ({ack_cnt, ack_cyc[0], rdata0} !== {32'd1, 32'd3, 32'h0}) begin
      n_bad++;
      $display("FAIL abort_reread: got cnt=%0d cyc=%0d rdata0=%h required 1/3/0",
               ack_cnt, ack_cyc[0], rdata0);
    end
  endtask

  task automatic test_held_req();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd6; wdata0 = 32'h11;
    collect(20, 2, -1);
    clear_reqs();
    step();
    n_cmp++;
    if ({ack_cyc[0], ack_who[0], ack_cyc[1], ack_who[1]} !== {32'd3, 32'd0, 32'd7, 32'd0}) begin
      n_bad++;
      $display("FAIL held_repeat: got %0d/%0d %0d/%0d required 3/0 7/0",
               ack_cyc[0], ack_who[0], ack_cyc[1], ack_who[1]);
    end
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd6;
    wr1 = 1'b0; addr1 = 4'd6;
    collect(30, 3, 1);
    clear_reqs();
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ack_cyc[k] !== 3 + 4 * k || ack_who[k] !== k % 2) begin
        n_bad++;
        $display("FAIL held_rr_ack%0d: got cyc=%0d who=%0d required cyc=%0d who=%0d", k,
                 ack_cyc[k], ack_who[k], 3 + 4 * k, k % 2);
      end
    end
    n_cmp++;
    if ({rdata0, rdata1, both_cnt} !== {32'h11, 32'h11, 32'd0}) begin
      n_bad++;
      $display("FAIL held_data: got %h %h both=%0d required 11 11 0", rdata0, rdata1, both_cnt);
    end
  endtask

  initial begin
    clear_reqs();
    rst = 1'b1;
    test_reset();
    test_init();
    test_write_read();
    test_rr_both();
    test_req_during_init();
    test_reset_in_wait();
    test_held_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
